psd_avg_ctrl: RTL and testbench

//  Parametrised post-PSD averager for the lock-in chain: X/Y demodulator outputs -> averaged X/Y.
//  Two runtime modes: decimating block (boxcar) average of 2^L samples, or exponential moving average (EMA), time constant 2^L.

---
 rtl/psd_avg_pkg.sv | 28 ++
 rtl/psd_avg_lane.sv | 54 +++++
 rtl/psd_avg_ctrl.sv | 126 ++++++++++++
 tb/tb_psd_avg_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psd_avg_pkg.sv
// Shared constants and arithmetic helpers for the post-PSD X/Y averager.
package psd_avg_pkg;

   localparam logic MODE_BLOCK = 1'b0;
   localparam logic MODE_EMA   = 1'b1;

   // Working width of the rounder; wide enough for any practical DW+MAX_LOG2N.
   localparam int RS_W = 128;

   function automatic int acc_w(input int dw, input int max_log2n);
      return dw + max_log2n;
   endfunction

   // Divide by 2^l, rounding half toward +inf; l==0 passes the value through.
   function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] acc,
                                                          input int unsigned l);
      logic signed [RS_W-1:0] bias;
      logic signed [RS_W-1:0] res;
      if (l == 0) begin
         res = acc;
      end else begin
         bias = RS_W'(1) << (l - 1);
         res  = (acc + bias) >>> l;
      end
      return res;
   endfunction

endpackage

// File: rtl/psd_avg_lane.sv
// One channel of the averager: accumulator (block sum or EMA state) and output rounder.
module psd_avg_lane
   import psd_avg_pkg::*;
#(
   parameter int DW        = 36,
   parameter int MAX_LOG2N = 7,
   parameter int LW        = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clear,
   input  logic          i_en,
   input  logic          i_load,
   input  logic          i_prime,
   input  logic          i_ema,
   input  logic [LW-1:0] i_lq,
   input  logic [DW-1:0] i_x,
   input  logic          i_upd,
   input  logic [LW-1:0] i_lo,
   output logic [DW-1:0] o_y
);

   localparam int ACC_W = acc_w(DW, MAX_LOG2N);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [RS_W-1:0]  rs;

   assign x_ext = {{MAX_LOG2N{i_x[DW-1]}}, i_x};
   assign rs    = round_shift(RS_W'(acc), 32'(i_lo));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc <= '0;
         o_y <= '0;
      end else if (i_clear) begin
         acc <= '0;
      end else begin
         if (i_en) begin
            if (i_ema) begin
               if (i_prime) acc <= x_ext <<< i_lq;
               else         acc <= acc - (acc >>> i_lq) + x_ext;
            end else if (i_load) begin
               // first sample of a block overwrites, so blocks run back to back
               acc <= x_ext;
            end else begin
               acc <= acc + x_ext;
            end
         end
         if (i_upd) o_y <= rs[DW-1:0];
      end
   end

endmodule

// File: rtl/psd_avg_ctrl.sv
// Post-PSD X/Y averager: decimating boxcar of 2^L samples or EMA with time constant 2^L.
module psd_avg_ctrl
   import psd_avg_pkg::*;
#(
   parameter int DW        = 36,
   parameter int MAX_LOG2N = 7,
   parameter int LW        = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [DW-1:0]        i_X,
   input  logic [DW-1:0]        i_Y,
   input  logic [LW-1:0]        i_log2_n,
   input  logic                 i_mode,
   input  logic                 i_clear,
   output logic [DW-1:0]        o_X,
   output logic [DW-1:0]        o_Y,
   output logic                 o_valid,
   output logic [MAX_LOG2N:0]   o_fill
);

   localparam int FW = MAX_LOG2N + 1;

   logic [LW-1:0] l_in, eff_l, lq, l1, l2;
   logic          eff_mode, modeq, primed;
   logic [FW-1:0] fill, fill_lim;
   logic          acc_v, load_c, last_c;
   logic [1:0]    vld_pipe;
   logic [DW-1:0] x1, y1;
   logic          load1, prime1, ema1, last1;

   assign l_in  = (i_log2_n > LW'(MAX_LOG2N)) ? LW'(MAX_LOG2N) : i_log2_n;
   assign acc_v = i_valid & ~i_clear;

   // Config is taken live at a block boundary, otherwise from the latched copy.
   always_comb begin
      eff_mode = modeq;
      eff_l    = lq;
      if (fill == '0) begin
         eff_mode = i_mode;
         eff_l    = l_in;
      end
      fill_lim = (FW'(1) << eff_l) - FW'(1);
      load_c   = (fill == '0);
      last_c   = (eff_mode == MODE_EMA) || (fill == fill_lim);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fill     <= '0;
         lq       <= '0;
         modeq    <= MODE_BLOCK;
         primed   <= 1'b0;
         vld_pipe <= '0;
         x1       <= '0;
         y1       <= '0;
         l1       <= '0;
         l2       <= '0;
         load1    <= 1'b0;
         prime1   <= 1'b0;
         ema1     <= 1'b0;
         last1    <= 1'b0;
         o_valid  <= 1'b0;
      end else if (i_clear) begin
         fill     <= '0;
         lq       <= l_in;
         modeq    <= i_mode;
         primed   <= 1'b0;
         vld_pipe <= '0;
         o_valid  <= 1'b0;
      end else begin
         vld_pipe[0] <= acc_v;
         if (acc_v) begin
            lq     <= eff_l;
            modeq  <= eff_mode;
            x1     <= i_X;
            y1     <= i_Y;
            l1     <= eff_l;
            ema1   <= (eff_mode == MODE_EMA);
            load1  <= load_c;
            prime1 <= ~primed;
            last1  <= last_c;
            // any block-mode sample leaves the EMA needing a fresh prime
            primed <= (eff_mode == MODE_EMA);
            fill   <= last_c ? '0 : fill + FW'(1);
         end
         vld_pipe[1] <= vld_pipe[0] & last1;
         l2          <= l1;
         o_valid     <= vld_pipe[1];
      end
   end

   assign o_fill = fill;

   psd_avg_lane #(.DW(DW), .MAX_LOG2N(MAX_LOG2N), .LW(LW)) u_lane_x (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_en    (vld_pipe[0]),
      .i_load  (load1),
      .i_prime (prime1),
      .i_ema   (ema1),
      .i_lq    (l1),
      .i_x     (x1),
      .i_upd   (vld_pipe[1]),
      .i_lo    (l2),
      .o_y     (o_X)
   );

   psd_avg_lane #(.DW(DW), .MAX_LOG2N(MAX_LOG2N), .LW(LW)) u_lane_y (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_en    (vld_pipe[0]),
      .i_load  (load1),
      .i_prime (prime1),
      .i_ema   (ema1),
      .i_lq    (l1),
      .i_x     (y1),
      .i_upd   (vld_pipe[1]),
      .i_lo    (l2),
      .o_y     (o_Y)
   );

endmodule

// File: tb/tb_psd_avg_ctrl.sv
// Scoreboard bench for psd_avg_ctrl: directed cases plus randomized traffic against a sample-list model.
module tb_psd_avg_ctrl;

   localparam int DW        = 36;
   localparam int MAX_LOG2N = 7;
   localparam int LW        = 3;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_valid = 1'b0;
   logic [DW-1:0]     i_X = '0;
   logic [DW-1:0]     i_Y = '0;
   logic [LW-1:0]     i_log2_n = '0;
   logic              i_mode = 1'b0;
   logic              i_clear = 1'b0;
   logic [DW-1:0]     o_X, o_Y;
   logic              o_valid;
   logic [MAX_LOG2N:0] o_fill;

   always #5 i_clk = ~i_clk;

   psd_avg_ctrl #(.DW(DW), .MAX_LOG2N(MAX_LOG2N), .LW(LW)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .i_X      (i_X),
      .i_Y      (i_Y),
      .i_log2_n (i_log2_n),
      .i_mode   (i_mode),
      .i_clear  (i_clear),
      .o_X      (o_X),
      .o_Y      (o_Y),
      .o_valid  (o_valid),
      .o_fill   (o_fill)
   );

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int            e;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } exp_t;

   exp_t   sb[$];
   int     n_chk = 0;
   int     n_fail = 0;

   // reference model state
   longint        blk_x[$];
   longint        blk_y[$];
   int            cur_l = 0;
   bit            cur_mode = 1'b0;
   bit            primed = 1'b0;
   longint        ema_x = 0, ema_y = 0;
   int            m_fill = 0;
   logic [DW-1:0] last_x = '0, last_y = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // average of a sum over 2^l, rounded half up
   function automatic longint div_round(input longint a, input int l);
      if (l == 0) return a;
      return (a + (longint'(1) << (l - 1))) >>> l;
   endfunction

   function automatic longint rnd36();
      logic [63:0] r;
      if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 400)) - 200;
      r = {$urandom(), $urandom()};
      return $signed(r) >>> 28;
   endfunction

   task automatic push_exp(input int e, input longint ex, input longint ey);
      exp_t t;
      t.e = e;
      t.x = DW'(ex);
      t.y = DW'(ey);
      sb.push_back(t);
   endtask

   task automatic model_sample(input int e, input longint x, input longint y, input int l, input bit m);
      int     lc;
      longint sx, sy;
      lc = (l > MAX_LOG2N) ? MAX_LOG2N : l;
      if (blk_x.size() == 0) begin
         cur_l    = lc;
         cur_mode = m;
      end
      if (cur_mode) begin
         if (!primed) begin
            ema_x = x * (longint'(1) << cur_l);
            ema_y = y * (longint'(1) << cur_l);
         end else begin
            ema_x = ema_x - (ema_x >>> cur_l) + x;
            ema_y = ema_y - (ema_y >>> cur_l) + y;
         end
         primed = 1'b1;
         m_fill = 0;
         push_exp(e + 2, div_round(ema_x, cur_l), div_round(ema_y, cur_l));
      end else begin
         primed = 1'b0;
         blk_x.push_back(x);
         blk_y.push_back(y);
         if (blk_x.size() == (1 << cur_l)) begin
            sx = 0;
            sy = 0;
            foreach (blk_x[i]) begin
               sx += blk_x[i];
               sy += blk_y[i];
            end
            push_exp(e + 2, div_round(sx, cur_l), div_round(sy, cur_l));
            blk_x.delete();
            blk_y.delete();
         end
         m_fill = blk_x.size();
      end
   endtask

   // one clock edge worth of stimulus, applied at the falling edge
   task automatic drive(input bit v, input longint x, input longint y, input int l, input bit m, input bit clr);
      int e;
      @(negedge i_clk);
      e        = cyc + 1;
      i_valid  = v;
      i_X      = DW'(x);
      i_Y      = DW'(y);
      i_log2_n = LW'(l);
      i_mode   = m;
      i_clear  = clr;
      if (clr) begin
         while (sb.size() > 0 && sb[$].e >= e) void'(sb.pop_back());
         blk_x.delete();
         blk_y.delete();
         primed = 1'b0;
         m_fill = 0;
      end else if (v) begin
         model_sample(e, x, y, l, m);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, int'(i_log2_n), i_mode, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_clear = 1'b0;
      sb.delete();
      blk_x.delete();
      blk_y.delete();
      primed = 1'b0;
      m_fill = 0;
      last_x = '0;
      last_y = '0;
      #1;
      check("rst_o_X", o_X, 0);
      check("rst_o_Y", o_Y, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_fill", o_fill, 0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // monitor: compares every edge, independent of stimulus
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (o_valid) begin
            if (sb.size() == 0) begin
               check("o_valid_spurious", o_valid, 0);
            end else begin
               exp_t t;
               t = sb.pop_front();
               check("latency", 64'(cyc), 64'(t.e));
               check("o_X", o_X, t.x);
               check("o_Y", o_Y, t.y);
               last_x = t.x;
               last_y = t.y;
            end
         end else begin
            if (sb.size() > 0 && sb[0].e <= cyc) begin
               check("o_valid_missing", o_valid, 1);
               void'(sb.pop_front());
            end
            check("hold_X", o_X, last_x);
            check("hold_Y", o_Y, last_y);
         end
         check("o_fill", o_fill, 64'(m_fill));
      end
   end

   initial begin
      longint maxv, minv;
      bit     m;
      int     l;
      maxv = (longint'(1) << (DW - 1)) - 1;
      minv = -(longint'(1) << (DW - 1));

      do_reset();
      idle(2);

      // block L=2
      for (int i = 0; i < 4; i++) drive(1'b1, 100, -100, 2, 1'b0, 1'b0);
      idle(3);

      // rounding L=1 and full-scale inputs
      drive(1'b1, 1, -1, 1, 1'b0, 1'b0);
      drive(1'b1, 2, -2, 1, 1'b0, 1'b0);
      drive(1'b1, -1, 3, 1, 1'b0, 1'b0);
      drive(1'b1, -2, 4, 1, 1'b0, 1'b0);
      drive(1'b1, maxv, minv, 1, 1'b0, 1'b0);
      drive(1'b1, maxv, minv, 1, 1'b0, 1'b0);
      idle(3);

      // pass-through L=0
      drive(1'b1, 7, -7, 0, 1'b0, 1'b0);
      drive(1'b1, -9, 9, 0, 1'b0, 1'b0);
      idle(3);

      // gaps between samples
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 100, -100, 2, 1'b0, 1'b0);
         idle(3);
      end

      // L change mid-block
      drive(1'b1, 10, 20, 2, 1'b0, 1'b0);
      drive(1'b1, 11, 21, 2, 1'b0, 1'b0);
      drive(1'b1, 12, 22, 3, 1'b0, 1'b0);
      drive(1'b1, 13, 23, 3, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, 5 * i, -3 * i, 3, 1'b0, 1'b0);
      idle(3);

      // EMA L=2
      drive(1'b1, 0, 0, 2, 1'b1, 1'b0);
      drive(1'b1, 400, -400, 2, 1'b1, 1'b0);
      drive(1'b1, 400, -400, 2, 1'b1, 1'b0);
      idle(3);

      // clear mid-block, clear with valid, clear dropping in-flight result
      for (int i = 0; i < 3; i++) drive(1'b1, 50, 60, 2, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 2, 1'b0, 1'b1);
      drive(1'b1, 999, 999, 2, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 8, -8, 2, 1'b0, 1'b0);
      idle(3);
      for (int i = 0; i < 4; i++) drive(1'b1, 20, 30, 2, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 2, 1'b0, 1'b1);
      idle(3);

      // async reset mid-block
      drive(1'b1, 40, 40, 2, 1'b0, 1'b0);
      drive(1'b1, 40, 40, 2, 1'b0, 1'b0);
      do_reset();
      idle(2);

      // randomized traffic
      m = 1'b0;
      l = 2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) m = ~m;
         if ($urandom_range(0, 29) == 0) l = $urandom_range(0, 7);
         drive($urandom_range(0, 9) < 7, rnd36(), rnd36(), l, m, $urandom_range(0, 79) == 0);
      end
      idle(6);
      check("drain", 64'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
